prog_sequencer: RTL
===================

Name: prog_sequencer

Overview:
- Control-side counterpart of the program counter in the 3BC basic processor.
- Runs the testbench start/done handshake.
- Drives the PC's En, its clear and its branch inputs (BranchEn, Offset).
- Decodes branch/halt from the fetched instruction and resolves branch offsets through a programmable 16-entry target LUT; counts executed cycles and enforces a timeout.

Parameters:
- PC_W, 10, program counter / offset width
- LUT_AW, 4, branch LUT index width (16 entries)
- CNT_W, 16, cycle counter width
- MAX_CYCLES, 16'hFFFF, RUN cycles before forced timeout

Ports:
- Clk  input  1  clock, all state changes on posedge
- Reset  input  1  synchronous, active-high reset
- Start  input  1  testbench request; program launches on its falling edge
- Instr  input  9  instruction fetched at current PC
- CondFlag  input  1  registered ALU condition flag
- LutWe  input  1  LUT write enable
- LutAddr  input  LUT_AW  LUT write index
- LutData  input  PC_W  LUT write data (signed offset)
- PcClear  output  1  forces PC to 0 (drives PC reset input)
- En  output  1  PC count enable
- BranchEn  output  1  take branch this cycle
- Offset  output  PC_W  signed branch offset to PC
- Done  output  1  program finished (level)
- Timeout  output  1  run aborted by cycle limit
- CycleCount  output  CNT_W  RUN cycles of last/current program

Behaviour:
- Reset values:
  - state=IDLE; all LUT entries=0; CycleCount=0.
  - Done, Timeout, En, BranchEn and PcClear all 0; Offset=0.
- Decode fields: opcode=Instr[8:5]; BR=4'b1100 (index=Instr[3:0]); HALT=4'b1111.
- FSM:
  - IDLE: Start=1 -> ARM.
  - ARM: wait while Start=1. Start=0 -> LAUNCH. Done and Timeout cleared on entry.
  - LAUNCH: one cycle. PcClear=1; CycleCount<=0 -> RUN.
  - RUN: each cycle CycleCount+=1, halt cycle included.
    - opcode==HALT -> DONE.
    - CycleCount==MAX_CYCLES-1 (no halt) -> DONE with Timeout<=1.
  - DONE: Done=1, CycleCount held. Start=1 -> ARM. Done and Timeout stay set until ARM is entered.
- En (combinational) = (state==RUN) && opcode!=HALT. The PC therefore holds at the HALT address.
- BranchEn (combinational) = (state==RUN) && opcode==BR && CondFlag. Zero latency: the PC samples it at the same edge.
- Offset (combinational) = LUT[Instr[3:0]] when BranchEn, else 0.
  - Two's complement; PC addition wraps mod 2^PC_W. Example: offset 10'h3FF = -1.
- LUT write: synchronous, allowed in any state. The new value is visible the cycle after the write. A same-cycle read of the same index returns the old value.
- Start edges are ignored in LAUNCH and RUN; Start high in RUN does not restart the program.
- Non-BR, non-HALT opcodes: En=1, BranchEn=0 (sequential fetch).
- Reset mid-RUN: next edge returns to IDLE with En=0 and Done=0. LUT contents are cleared.
- CycleCount saturates at MAX_CYCLES-1, which coincides with timeout; it never wraps.

Test Plan:
- Reset, then Start 1 for 3 cycles then 0 -> PcClear=1 for exactly 1 cycle, then En=1 from the next cycle; CycleCount increments 1,2,3 while ProgCtr goes 0,1,2.
- LUT[5]=10'h3FC, Instr=9'b1100_0_0101, CondFlag=1 at PC=20 -> BranchEn=1, Offset=10'h3FC in that cycle; PC becomes 16. Same instruction with CondFlag=0 -> BranchEn=0, Offset=0; PC becomes 21.
- HALT (9'b1111_00000) fetched at PC=7 after 8 RUN cycles -> En=0 that cycle, PC holds 7, Done=1 next cycle, CycleCount=8, Timeout=0.
- MAX_CYCLES=32 override, program never halts -> after 32 RUN cycles Done=1, Timeout=1, CycleCount=31, En=0.
- Write LUT[2]=10'd4 in the same cycle a BR to index 2 executes (old value 0) -> Offset=0 that cycle; the next BR to index 2 gives Offset=4.
- Reset asserted mid-RUN at PC=12 -> next cycle En=0, Done=0, state IDLE. A new Start pulse relaunches with PcClear.

Source files
------------

// File: rtl/prog_sequencer.sv
// Control sequencer for the 3BC program counter: start/done handshake,
// branch/halt decode, branch offset LUT, cycle counting and timeout.
module prog_sequencer #(
  parameter int PC_W   = 10,
  parameter int LUT_AW = 4,
  parameter int CNT_W  = 16,
  parameter logic [CNT_W-1:0] MAX_CYCLES = 16'hFFFF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [8:0]        Instr,
  input  logic              CondFlag,
  input  logic              LutWe,
  input  logic [LUT_AW-1:0] LutAddr,
  input  logic [PC_W-1:0]   LutData,
  output logic              PcClear,
  output logic              En,
  output logic              BranchEn,
  output logic [PC_W-1:0]   Offset,
  output logic              Done,
  output logic              Timeout,
  output logic [CNT_W-1:0]  CycleCount
);

  localparam logic [3:0] OP_BR   = 4'b1100;
  localparam logic [3:0] OP_HALT = 4'b1111;
  localparam int DEPTH = 1 << LUT_AW;
  localparam logic [CNT_W-1:0] LIMIT = MAX_CYCLES - 1'b1;

  typedef enum logic [2:0] {
    IDLE, ARM, LAUNCH, RUN, DONE
  } state_t;

  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic done_q, done_d;
  logic tmo_q, tmo_d;
  logic [PC_W-1:0] lut [DEPTH];

  logic [3:0] opcode;
  logic [LUT_AW-1:0] idx;
  logic is_br, is_halt, at_limit;
  logic unused_instr;

  assign opcode   = Instr[8:5];
  assign idx      = Instr[LUT_AW-1:0];
  assign is_br    = (opcode == OP_BR);
  assign is_halt  = (opcode == OP_HALT);
  assign at_limit = (cnt_q == LIMIT);
  assign unused_instr = ^Instr;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      tmo_q   <= tmo_d;
    end
  end

  // Write lands at the edge; a same-cycle read sees the old entry.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        lut[i] <= '0;
      end
    end else if (LutWe) begin
      lut[LutAddr] <= LutData;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    done_d   = done_q;
    tmo_d    = tmo_q;
    En       = 1'b0;
    BranchEn = 1'b0;
    PcClear  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (Start) begin
          state_d = ARM;
          done_d  = 1'b0;
          tmo_d   = 1'b0;
        end
      end
      ARM: begin
        if (!Start) begin
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        PcClear = 1'b1;
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        En       = !is_halt;
        BranchEn = is_br && CondFlag;
        if (!at_limit) begin
          cnt_d = cnt_q + 1'b1;
        end
        // Halt wins over a timeout landing on the same cycle.
        if (is_halt) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else if (at_limit) begin
          state_d = DONE;
          done_d  = 1'b1;
          tmo_d   = 1'b1;
        end
      end
      DONE: begin
        if (Start) begin
          state_d = ARM;
          done_d  = 1'b0;
          tmo_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign Offset     = BranchEn ? lut[idx] : '0;
  assign Done       = done_q;
  assign Timeout    = tmo_q;
  assign CycleCount = cnt_q;

endmodule
